key_expand_128: RTL and testbench
=================================

KEY_EXPAND_128 -- requirements
Module: key_expand_128

Interface
REQ-001 Parameters: none; AES-128 only (Nk=4, Nr=10) SHALL be hard-wired.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin expansion of key_in; sampled only in IDLE.
REQ-005 key_in  input  128  cipher key, word w0 = [127:96], captured on accepted start.
REQ-006 sw_out  output  32  RotWord(w3) driven to the external 4-byte S-box substitution stage.
REQ-007 sw_in  input  32  SubWord(sw_out) returned combinationally from that stage.
REQ-008 rk_ready  input  1  downstream accepts round_key this cycle.
REQ-009 rk_valid  output  1  round_key/round_num valid.
REQ-010 round_key  output  128  current round key.
REQ-011 round_num  output  4  index 0..10 of round_key.
REQ-012 busy  output  1  high in EXPAND.
REQ-013 done  output  1  one-cycle pulse after round 10 is accepted.
REQ-014 rd_addr  input  4  cache read index (see Configuration).
REQ-015 rd_key  output  128  cache read data (see Configuration).

Function
REQ-016 FSM SHALL have states IDLE and EXPAND.
REQ-017 IDLE + start=1: load key_in into w, round_num<=0, rk_valid<=1, go EXPAND; round key 0 visible the cycle after start.
REQ-018 IDLE + start=0: hold; rk_valid=0.
REQ-019 EXPAND: a handshake occurs when rk_valid & rk_ready are both high.
REQ-020 Handshake with round_num<10: w<=next(w), round_num<=round_num+1, rk_valid stays 1.
REQ-021 Handshake with round_num=10: rk_valid<=0, done<=1 for one cycle, go IDLE.
REQ-022 No handshake: round_key, round_num, rk_valid SHALL hold unchanged (backpressure, no limit on stall length).
REQ-023 next(w): t = sw_in XOR {Rcon[round_num+1],24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-024 sw_out SHALL equal {w3[23:0], w3[31:24]} at all times (zero in reset/IDLE after reset).
REQ-025 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-026 start while busy SHALL be ignored; in-progress sequence unaffected.
REQ-027 With rk_ready held high, rounds 0..10 SHALL appear on 11 consecutive cycles, done on the 12th.
REQ-028 start in the same cycle as done is high SHALL be ignored (FSM already IDLE next cycle; start sampled then).
REQ-029 round_key SHALL equal w; no additional pipeline register.

Reset
REQ-030 rst=1 at any edge, including mid-expansion: state IDLE, w=0, round_key=0, round_num=0, rk_valid=0, busy=0, done=0.
REQ-031 rst SHALL take priority over start and rk_ready in the same cycle.
REQ-032 Cache contents (when compiled in) SHALL clear to zero on rst.

Configuration
REQ-033 Macro KEY_EXPAND_CACHE_EN.
REQ-034 Defined: each round key SHALL be written into an 11-entry store at index round_num on its handshake; rd_key = store[rd_addr] combinationally; rd_addr>10 returns 0; a new start SHALL overwrite entries as rounds complete.
REQ-035 Undefined: no store; rd_key SHALL be constant 0; rd_addr ignored.

Verification
REQ-036 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round1 a0fafe1788542cb123a339392a6c7605, round10 d014f9a8c9ee2589e13f0cc8b6630ca6, done 12 cycles after start.
REQ-037 Key all-zero -> round1 62636363626363636263636362636363, round_num increments 0..10 exactly once each.
REQ-038 Same FIPS key, rk_ready low for 5 cycles at round 3 -> round_key/round_num frozen at round 3 for those cycles, then sequence resumes with identical values.
REQ-039 rst pulsed while round_num=6 -> next cycle all outputs 0, IDLE; fresh start reproduces round 1 correctly.
REQ-040 start with different key asserted at round 4 -> ignored; original key sequence completes unchanged.
REQ-041 With KEY_EXPAND_CACHE_EN, after FIPS run, rd_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6, rd_addr=15 -> 0; without macro rd_key=0 for all rd_addr.

Source files
------------

// File: rtl/key_expand_128.sv
// AES-128 key schedule: emits round keys 0..10 under a valid/ready handshake, SubWord done externally.
// Optional round-key store enabled by defining KEY_EXPAND_CACHE_EN.
module key_expand_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [31:0]  sw_out,
    input  logic [31:0]  sw_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    logic [0:0]   state;
    logic [127:0] w;
    logic [7:0]   rcon;
    logic [31:0]  t;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic         handshake;

    // Rcon for the round being produced, i.e. Rcon[round_num+1]
    always_comb begin
        rcon = 8'h00;
        case (round_num)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign sw_out    = {w[23:0], w[31:24]};
    assign t         = sw_in ^ {rcon, 24'h000000};
    assign w0n       = w[127:96] ^ t;
    assign w1n       = w[95:64]  ^ w0n;
    assign w2n       = w[63:32]  ^ w1n;
    assign w3n       = w[31:0]   ^ w2n;
    assign handshake = (state == EXPAND) && rk_valid && rk_ready;
    assign busy      = (state == EXPAND);
    assign round_key = w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w         <= '0;
            round_num <= '0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w         <= key_in;
                        round_num <= 4'd0;
                        rk_valid  <= 1'b1;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (handshake) begin
                        if (round_num == 4'd10) begin
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            w         <= {w0n, w1n, w2n, w3n};
                            round_num <= round_num + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_EXPAND_CACHE_EN
    logic [127:0] store [11];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) store[i] <= '0;
        end else if (handshake) begin
            for (int i = 0; i < 11; i++) begin
                if (round_num == 4'(i)) store[i] <= w;
            end
        end
    end

    // Indices 11..15 match no entry and read back as zero
    always_comb begin
        rd_key = '0;
        for (int i = 0; i < 11; i++) begin
            if (rd_addr == 4'(i)) rd_key = store[i];
        end
    end
`else
    // rd_addr is folded in only so the port stays referenced; the result is always zero
    assign rd_key = {128{1'b0}} & {128{^rd_addr}};
`endif

endmodule

// File: tb/tb_key_expand_128.sv
// Randomized self-checking bench for key_expand_128 against a FIPS-197 style key schedule model.
// Cache expectations follow KEY_EXPAND_CACHE_EN the same way the design does.
module tb_key_expand_128;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [31:0]  sw_out;
    logic [31:0]  sw_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         busy;
    logic         done;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk [11];
    logic [127:0] cap_rk [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

    key_expand_128 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .sw_out    (sw_out),
        .sw_in     (sw_in),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_num (round_num),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_key    (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External S-box stage
    assign sw_in = {sbox_tab[sw_out[31:24]], sbox_tab[sw_out[23:16]],
                    sbox_tab[sw_out[15:8]],  sbox_tab[sw_out[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic buildSbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (v != 0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-by-word key expansion as written in FIPS-197
    task automatic computeSchedule(input logic [127:0] key);
        logic [31:0] ww [44];
        logic [31:0] temp;
        logic [7:0]  rc;
        ww[0] = key[127:96]; ww[1] = key[95:64]; ww[2] = key[63:32]; ww[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = ww[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_tab[temp[31:24]], sbox_tab[temp[23:16]],
                        sbox_tab[temp[15:8]],  sbox_tab[temp[7:0]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            ww[i] = ww[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Runs one full expansion starting at a negedge; stall_round holds rk_ready low 5 cycles,
    // inject_round drives a competing start with another key while that round is presented.
    task automatic applyStimulus(input logic [127:0] key, input int ready_pct, input int stall_round,
                                 input int inject_round, output int done_lat);
        int          n, cyc, stall_left;
        logic        hs;
        logic [31:0] w3;
        computeSchedule(key);
        n = 0; cyc = 0; stall_left = 5;
        start = 1'b1; key_in = key; rk_ready = 1'b0;
        @(negedge clk); cyc = 1;
        start = 1'b0;
        while (n <= 10 && cyc < 300) begin
            w3 = exp_rk[n][31:0];
            checkOutput("rk_valid", rk_valid, 1);
            checkOutput("round_num", round_num, n);
            checkOutput("round_key", round_key, exp_rk[n]);
            checkOutput("busy", busy, 1);
            checkOutput("done_low", done, 0);
            checkOutput("sw_out", sw_out, {w3[23:0], w3[31:24]});
            cap_rk[n] = round_key;
            if (n == stall_round && stall_left > 0) begin
                rk_ready = 1'b0;
                stall_left--;
            end else begin
                rk_ready = ($urandom_range(99) < ready_pct);
            end
            if (n == inject_round) begin
                start = 1'b1;
                key_in = ~key;
            end else begin
                start = 1'b0;
            end
            hs = rk_ready;
            @(negedge clk); cyc++;
            if (hs) n++;
        end
        rk_ready = 1'b0; start = 1'b0;
        checkOutput("round_budget", n, 11);
        checkOutput("done_pulse", done, 1);
        checkOutput("valid_after", rk_valid, 0);
        checkOutput("busy_after", busy, 0);
        done_lat = cyc;
        @(negedge clk);
        checkOutput("done_clear", done, 0);
        checkOutput("idle_valid", rk_valid, 0);
    endtask

    task automatic checkCache();
        logic [127:0] expv;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
`ifdef KEY_EXPAND_CACHE_EN
            expv = (i <= 10) ? exp_rk[i] : '0;
`else
            expv = '0;
`endif
            checkOutput("rd_key", rd_key, expv);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          lat;
        int          guard;
        logic [127:0] rkey;

        rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0; rd_addr = 4'd0;
        buildSbox();
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", rk_valid, 0);
        checkOutput("rst_key", round_key, 0);
        checkOutput("rst_num", round_num, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sw_out", sw_out, 0);
        checkOutput("rst_rd_key", rd_key, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] FIPS-197 key, rk_ready held high");
        applyStimulus(FIPS_KEY, 100, -1, -1, lat);
        checkOutput("fips_round1", cap_rk[1], FIPS_R1);
        checkOutput("fips_round10", cap_rk[10], FIPS_R10);
        checkOutput("fips_done_latency", lat, 12);
        checkCache();

        $display("[TB] all-zero key");
        applyStimulus('0, 100, -1, -1, lat);
        checkOutput("zero_round1", cap_rk[1], ZERO_R1);

        $display("[TB] backpressure at round 3");
        applyStimulus(FIPS_KEY, 100, 3, -1, lat);
        checkOutput("stall_round10", cap_rk[10], FIPS_R10);
        checkOutput("stall_latency", lat, 17);

        $display("[TB] start ignored while busy");
        applyStimulus(FIPS_KEY, 100, -1, 4, lat);
        checkOutput("inject_round10", cap_rk[10], FIPS_R10);

        $display("[TB] reset mid-expansion");
        start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (round_num != 4'd6 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_round6", round_num, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rk_ready = 1'b0;
        checkOutput("midrst_valid", rk_valid, 0);
        checkOutput("midrst_key", round_key, 0);
        checkOutput("midrst_num", round_num, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_sw_out", sw_out, 0);
        checkOutput("midrst_rd_key", rd_key, 0);
        @(negedge clk);
        checkOutput("midrst_idle", rk_valid, 0);
        applyStimulus(FIPS_KEY, 100, -1, -1, lat);
        checkOutput("restart_round1", cap_rk[1], FIPS_R1);

        $display("[TB] random keys with random backpressure");
        for (int k = 0; k < 6; k++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(rkey, 60, (k % 2 == 0) ? int'($urandom_range(10)) : -1, -1, lat);
            checkCache();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
